change_dispenser: RTL

//  Downstream of the vending controller: takes the change amount (change_due) computed after a vend
//  and pays it out from three coin tubes ($5, $2, $1), one coin eject pulse at a time.

---
 rtl/change_dispenser_if.sv | 44 ++++
 rtl/change_dispenser.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Change-payout bus between the vending controller/display path and change_dispenser.
// CHANGE_AUDIT_EN adds the total_paid audit counter to the bus.
interface change_if #(
    parameter int TUBE_W = 4
);
    logic              change_req;
    logic [7:0]        change_amt;
    logic              restock;
    logic              ready;
    logic              eject_5;
    logic              eject_2;
    logic              eject_1;
    logic              done;
    logic              short;
    logic [7:0]        remaining;
    logic [TUBE_W-1:0] tube5;
    logic [TUBE_W-1:0] tube2;
    logic [TUBE_W-1:0] tube1;
`ifdef CHANGE_AUDIT_EN
    logic [15:0]       total_paid;

    modport master (
        output change_req, change_amt, restock,
        input  ready, eject_5, eject_2, eject_1, done, short, remaining,
        input  tube5, tube2, tube1, total_paid
    );
    modport slave (
        input  change_req, change_amt, restock,
        output ready, eject_5, eject_2, eject_1, done, short, remaining,
        output tube5, tube2, tube1, total_paid
    );
`else
    modport master (
        output change_req, change_amt, restock,
        input  ready, eject_5, eject_2, eject_1, done, short, remaining,
        input  tube5, tube2, tube1
    );
    modport slave (
        input  change_req, change_amt, restock,
        output ready, eject_5, eject_2, eject_1, done, short, remaining,
        output tube5, tube2, tube1
    );
`endif
endinterface

// File: rtl/change_dispenser.sv
// Greedy $5/$2/$1 coin payout with per-tube stock tracking and timed eject pulses.
// Optional build macro CHANGE_AUDIT_EN adds a saturating total_paid counter.
module change_dispenser #(
    parameter int TUBE_DEPTH   = 15,
    parameter int TUBE_W       = 4,
    parameter int EJECT_CYCLES = 4,
    parameter int GAP_CYCLES   = 8
) (
    input  logic  clk,
    input  logic  rst,
    change_if.slave bus
);
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE, S_SHORT
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_remaining;
    logic [TUBE_W-1:0] r_tube5, r_tube2, r_tube1;
    logic              r_eject5, r_eject2, r_eject1;
    logic              r_done, r_short;
    logic [2:0]        w_coin;

    // Greedy pick for the current remaining amount; 0 means no coin can be paid.
    always_comb begin
        w_coin = 3'd0;
        if (r_remaining >= 8'd5 && r_tube5 != '0)
            w_coin = 3'd5;
        else if (r_remaining >= 8'd2 && r_tube2 != '0)
            w_coin = 3'd2;
        else if (r_tube1 != '0)
            w_coin = 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_remaining <= '0;
            r_tube5     <= TUBE_W'(TUBE_DEPTH);
            r_tube2     <= TUBE_W'(TUBE_DEPTH);
            r_tube1     <= TUBE_W'(TUBE_DEPTH);
            r_eject5    <= 1'b0;
            r_eject2    <= 1'b0;
            r_eject1    <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.restock) begin
                        r_tube5 <= TUBE_W'(TUBE_DEPTH);
                        r_tube2 <= TUBE_W'(TUBE_DEPTH);
                        r_tube1 <= TUBE_W'(TUBE_DEPTH);
                    end else if (bus.change_req) begin
                        r_remaining <= bus.change_amt;
                        if (bus.change_amt == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (r_remaining == 8'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_coin == 3'd0) begin
                        r_state <= S_SHORT;
                        r_short <= 1'b1;
                    end else begin
                        // Debit amount and tube on the edge the solenoid fires.
                        r_remaining <= r_remaining - {5'd0, w_coin};
                        r_state     <= S_EJECT;
                        r_cnt       <= CNT_W'(EJECT_CYCLES - 1);
                        case (w_coin)
                            3'd5: begin
                                r_tube5  <= r_tube5 - TUBE_W'(1);
                                r_eject5 <= 1'b1;
                            end
                            3'd2: begin
                                r_tube2  <= r_tube2 - TUBE_W'(1);
                                r_eject2 <= 1'b1;
                            end
                            default: begin
                                r_tube1  <= r_tube1 - TUBE_W'(1);
                                r_eject1 <= 1'b1;
                            end
                        endcase
                    end
                end
                S_EJECT: begin
                    if (r_cnt == '0) begin
                        r_eject5 <= 1'b0;
                        r_eject2 <= 1'b0;
                        r_eject1 <= 1'b0;
                        r_state  <= S_GAP;
                        r_cnt    <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0)
                        r_state <= S_SELECT;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_done  <= 1'b0;
                    r_short <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (r_state == S_IDLE) && !bus.restock;
    assign bus.eject_5   = r_eject5;
    assign bus.eject_2   = r_eject2;
    assign bus.eject_1   = r_eject1;
    assign bus.done      = r_done;
    assign bus.short     = r_short;
    assign bus.remaining = r_remaining;
    assign bus.tube5     = r_tube5;
    assign bus.tube2     = r_tube2;
    assign bus.tube1     = r_tube1;

`ifdef CHANGE_AUDIT_EN
    logic [15:0] r_total_paid;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] c);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, c};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Not touched by restock: this is a lifetime audit figure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_total_paid <= '0;
        else if (r_state == S_SELECT && r_remaining != 8'd0 && w_coin != 3'd0)
            r_total_paid <= sat_add(r_total_paid, w_coin);
    end

    assign bus.total_paid = r_total_paid;
`else
`endif
endmodule
